mul_seq_ctrl: RTL and testbench

- Sequential RV32M multiply controller for the KLP32 execute stage.
- Performs MUL/MULH/MULHSU/MULHU by iterative radix-2 shift-add.
- Sequences one n-bit ripple adder instance (carryin tied 0) across n iterations.
- Sits beside the ALU; the decode/issue logic drives it through a valid/ready handshake.

---
 rtl/mul_seq_ctrl.sv | 109 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-2 shift-add over one adder

// N-bit adder with carry-in tied low; the only adder the multiplier sequences
module mul_seq_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module mul_seq_ctrl #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start_valid,
    output logic         o_start_ready,
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_rs1,
    input  logic [N-1:0] i_rs2,
    input  logic         i_flush,
    output logic         o_result_valid,
    input  logic         i_result_ready,
    output logic [N-1:0] o_result,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_hi, r_lo, r_mcand, r_result;
    logic [1:0]     r_op;
    logic           r_sign;
    logic           w_accept, w_last;
    logic           w_a_neg, w_b_neg;
    logic [N-1:0]   w_a_mag, w_b_mag, w_addend, w_sum;
    logic           w_cout;
    logic [2*N-1:0] w_prod;

    // A is signed for MULH/MULHSU, B only for MULH; magnitudes stay unsigned so -2^(N-1) fits
    assign w_a_neg  = (i_op == 2'b01 || i_op == 2'b10) && i_rs1[N-1];
    assign w_b_neg  = (i_op == 2'b01) && i_rs2[N-1];
    assign w_a_mag  = w_a_neg ? -i_rs1 : i_rs1;
    assign w_b_mag  = w_b_neg ? -i_rs2 : i_rs2;
    assign w_addend = r_lo[0] ? r_mcand : '0;
    assign w_prod   = r_sign ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign o_result = r_result;

    mul_seq_adder #(.W(N)) u_adder (
        .i_a    (r_hi),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs; flush overrides every other transition
    always_comb begin
        w_next         = r_state;
        o_start_ready  = (r_state == IDLE);
        o_result_valid = (r_state == DONE);
        o_busy         = (r_state != IDLE);
        w_accept       = o_start_ready && i_start_valid && !i_flush;
        w_last         = (r_cnt == CW'(N - 1));
        case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: if (w_last) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (i_result_ready) w_next = IDLE;
        endcase
        if (i_flush) w_next = IDLE;
    end

    // Datapath: capture operands, shift-add each CALC cycle, sign-fix and select the half in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_op     <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= i_op;
            r_mcand <= w_a_mag;
            r_hi    <= '0;
            r_lo    <= w_b_mag;
            r_sign  <= w_a_neg ^ w_b_neg;
            r_cnt   <= '0;
        end else if (!i_flush && r_state == CALC) begin
            {r_hi, r_lo} <= {w_cout, w_sum, r_lo[N-1:1]};
            r_cnt        <= r_cnt + 1'b1;
        end else if (!i_flush && r_state == FIX) begin
            {r_hi, r_lo} <= w_prod;
            r_result     <= (r_op == 2'b00) ? w_prod[N-1:0] : w_prod[2*N-1:N];
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed table, randomized model comparison and multi-cycle corner sequences
module tb_mul_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start_valid = 1'b0;
    logic        o_start_ready;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic        i_flush = 1'b0;
    logic        o_result_valid;
    logic        i_result_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    mul_seq_ctrl #(.N(32), .CW(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start_valid  (i_start_valid),
        .o_start_ready  (o_start_ready),
        .i_op           (i_op),
        .i_rs1          (i_rs1),
        .i_rs2          (i_rs2),
        .i_flush        (i_flush),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_result       (o_result),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Exact product from sign/zero-extended operands; low 64 bits of the 64-bit wrap are exact
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb;
        logic [63:0] xa, xb, p;
        sa = (op == 2'd1) || (op == 2'd2);
        sb = (op == 2'd1);
        xa = {{32{sa & a[31]}}, a};
        xb = {{32{sb & b[31]}}, b};
        p  = xa * xb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        return ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge
    task automatic accept_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_op = op;
        i_rs1 = a;
        i_rs2 = b;
        i_start_valid = 1'b1;
        for (int k = 0; k < 100 && !o_start_ready; k++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        i_start_valid = 1'b0;
    endtask

    // e counts the accept edge as 1; bounded so a stuck design still reaches the summary
    task automatic wait_result(output logic [31:0] res, output int e);
        e = 1;
        while (o_result_valid !== 1'b1 && e < 200) begin
            @(posedge clk);
            #1;
            e++;
        end
        res = o_result;
    endtask

    task automatic handshake(input string name);
        i_result_ready = 1'b1;
        @(posedge clk);
        #1;
        i_result_ready = 1'b0;
        chk({name, "_valid_drop"}, o_result_valid, 0);
        chk({name, "_ready_back"}, o_start_ready, 1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int e;
        accept_op(op, a, b);
        wait_result(res, e);
        chk({name, "_latency"}, e, 34);
        chk({name, "_result"}, res, exp);
        handshake(name);
    endtask

    initial begin
        vec_t vecs [6];
        logic [31:0] res, held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic        seen;
        int e;
        vecs = '{
            '{2'd0, 32'd7,          32'd6,          32'h0000_002A},
            '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000}
        };

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_start_ready", o_start_ready, 1);
        chk("rst_result_valid", o_result_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_result", o_result, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), rop, ra, rb, model(rop, ra, rb));
        end

        // Backpressure in DONE, then a second request held high across the handshake
        accept_op(2'd1, 32'h1234_5678, 32'hFEDC_BA98);
        wait_result(held, e);
        chk("bp_result", held, model(2'd1, 32'h1234_5678, 32'hFEDC_BA98));
        i_op = 2'd3;
        i_rs1 = 32'hDEAD_BEEF;
        i_rs2 = 32'h0BAD_F00D;
        i_start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_hold", o_result_valid, 1);
            chk("bp_result_hold", o_result, held);
        end
        chk("bp_no_ready_in_done", o_start_ready, 0);
        i_result_ready = 1'b1;
        @(posedge clk);
        #1;
        i_result_ready = 1'b0;
        chk("b2b_idle_gap_valid", o_result_valid, 0);
        chk("b2b_idle_gap_busy", o_busy, 0);
        @(posedge clk);
        #1;
        i_start_valid = 1'b0;
        chk("b2b_accepted", o_busy, 1);
        wait_result(res, e);
        chk("b2b_latency", e, 34);
        chk("b2b_result", res, model(2'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        handshake("b2b");
        held = res;

        // Flush at CALC iteration 15
        accept_op(2'd0, 32'h0001_0001, 32'h0000_0003);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        chk("flush_busy", o_busy, 0);
        chk("flush_ready", o_start_ready, 1);
        chk("flush_result_kept", o_result, held);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen |= o_result_valid;
        end
        chk("flush_no_valid_pulse", seen, 0);
        run_op("mul_3x5", 2'd0, 32'd3, 32'd5, 32'd15);

        // Flush in IDLE blocks the accept for that cycle only
        i_op = 2'd0;
        i_rs1 = 32'd9;
        i_rs2 = 32'd11;
        i_start_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        chk("idle_flush_blocks", o_busy, 0);
        @(posedge clk);
        #1;
        i_start_valid = 1'b0;
        chk("idle_flush_then_accept", o_busy, 1);
        wait_result(res, e);
        chk("idle_flush_latency", e, 34);
        chk("idle_flush_result", res, 32'd99);
        handshake("idle_flush");

        // Asynchronous reset mid-cycle at CALC iteration 20
        accept_op(2'd3, 32'hFFFF_0000, 32'h0000_FFFF);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start_ready", o_start_ready, 1);
        chk("arst_valid", o_result_valid, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_result", o_result, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_post_ready", o_start_ready, 1);
        chk("arst_post_busy", o_busy, 0);
        run_op("post_reset", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, model(2'd2, 32'h8000_0000, 32'hFFFF_FFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
